// File: rtl/liteeth_sram_fifo_ctrl.sv
// rtl/liteeth_sram_fifo_ctrl.sv - 384x32 stream FIFO controller around a 1rw1r SRAM macro
//
// Wraps one liteeth_1rw1r_32w384d_32_sram macro as a stream FIFO. Writes use the
// RW port and reads use the R port. A 2-entry skid buffer absorbs the macro's
// 1-cycle read latency, so the FIFO moves 1 word/cycle in each direction.
//
// Optional feature macro: LITEETH_SRAM_FIFO_FLUSH_EN (adds the synchronous flush input)
//
// Ports:
//   clk, rst_n          single clock (also the macro clock), async active-low reset
//   flush               synchronous discard of all contents (only with the macro above)
//   in_valid/ready/data write stream (MAC or DMA side)
//   out_valid/ready/data read stream, registered from the skid head
//   level               words held: SRAM + read in flight + skid buffer
//   sram_*_rw1          macro RW port (write only); wmask tied all-ones
//   sram_*_r1, rd_r1    macro R port and its read data (valid 1 cycle after ce)
module liteeth_sram_fifo_ctrl #(
  parameter int BITS        = 32,
  parameter int DEPTH       = 384,
  parameter int ADDR_WIDTH  = 9,
  parameter int LEVEL_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef LITEETH_SRAM_FIFO_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   sram_ce_rw1,
  output logic                   sram_we_rw1,
  output logic [BITS-1:0]        sram_wmask_rw1,
  output logic [ADDR_WIDTH-1:0]  sram_addr_rw1,
  output logic [BITS-1:0]        sram_wd_rw1,
  output logic                   sram_ce_r1,
  output logic [ADDR_WIDTH-1:0]  sram_addr_r1,
  input  logic [BITS-1:0]        sram_rd_r1
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       mem_cnt, mem_cnt_nxt;
  logic                   inflight, inflight_nxt;
  logic [1:0]             skid_cnt, skid_cnt_nxt;
  logic [BITS-1:0]        skid_tail, head_nxt, tail_nxt;
  logic [LEVEL_WIDTH-1:0] level_nxt;
  logic                   do_flush, wr, pop, push, issue;
  logic [2:0]             occ_after;

`ifdef LITEETH_SRAM_FIFO_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (mem_cnt < DEPTH_C) & ~do_flush;
  assign wr       = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign push     = inflight & ~do_flush;

  // Skid slots that stay committed after this cycle's pop; a new read may
  // only be launched if its return still has a free slot.
  assign occ_after = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
  // Registered mem_cnt gate keeps a read off the address being written now.
  assign issue     = (mem_cnt != '0) & (occ_after < 3'd2) & ~do_flush;

  // Enables are gated by rst_n so the macro sees them drop asynchronously.
  assign sram_ce_rw1    = wr & rst_n;
  assign sram_we_rw1    = wr & rst_n;
  assign sram_wmask_rw1 = '1;
  assign sram_addr_rw1  = wr_ptr;
  assign sram_wd_rw1    = in_data;
  assign sram_ce_r1     = issue & rst_n;
  assign sram_addr_r1   = rd_ptr;

  always_comb begin
    skid_cnt_nxt = skid_cnt;
    head_nxt     = out_data;
    tail_nxt     = skid_tail;
    case ({push, pop})
      2'b10: begin
        if (skid_cnt == 2'd0) head_nxt = sram_rd_r1;
        else                  tail_nxt = sram_rd_r1;
        skid_cnt_nxt = skid_cnt + 2'd1;
      end
      2'b01: begin
        head_nxt     = skid_tail;
        skid_cnt_nxt = skid_cnt - 2'd1;
      end
      2'b11: begin
        if (skid_cnt == 2'd1) begin
          head_nxt = sram_rd_r1;
        end else begin
          head_nxt = skid_tail;
          tail_nxt = sram_rd_r1;
        end
      end
      default: ;
    endcase
    if (do_flush) skid_cnt_nxt = 2'd0;

    mem_cnt_nxt  = do_flush ? '0 : mem_cnt + CNT_W'(wr) - CNT_W'(issue);
    inflight_nxt = issue;
    level_nxt    = LEVEL_WIDTH'(mem_cnt_nxt) + LEVEL_WIDTH'(inflight_nxt)
                 + LEVEL_WIDTH'(skid_cnt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      inflight  <= 1'b0;
      skid_cnt  <= 2'd0;
      skid_tail <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      level     <= '0;
    end else begin
      if (do_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr)    wr_ptr <= bump(wr_ptr);
        if (issue) rd_ptr <= bump(rd_ptr);
      end
      mem_cnt   <= mem_cnt_nxt;
      inflight  <= inflight_nxt;
      skid_cnt  <= skid_cnt_nxt;
      skid_tail <= tail_nxt;
      out_data  <= head_nxt;
      out_valid <= (skid_cnt_nxt != 2'd0);
      level     <= level_nxt;
    end
  end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb/tb_liteeth_sram_fifo_ctrl.sv - self-checking bench for liteeth_sram_fifo_ctrl
module tb_liteeth_sram_fifo_ctrl;
  localparam int BITS  = 32;
  localparam int DEPTH = 384;
  localparam int AW    = 9;
  localparam int LW    = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] out_data;
  logic [LW-1:0]   level;
  logic            sram_ce_rw1, sram_we_rw1, sram_ce_r1;
  logic [BITS-1:0] sram_wmask_rw1, sram_wd_rw1;
  logic [AW-1:0]   sram_addr_rw1, sram_addr_r1;
  logic [BITS-1:0] sram_rd_r1;
`ifdef LITEETH_SRAM_FIFO_FLUSH_EN
  logic            flush = 1'b0;
`endif

  liteeth_sram_fifo_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEVEL_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LITEETH_SRAM_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_ce_rw1(sram_ce_rw1), .sram_we_rw1(sram_we_rw1), .sram_wmask_rw1(sram_wmask_rw1),
    .sram_addr_rw1(sram_addr_rw1), .sram_wd_rw1(sram_wd_rw1),
    .sram_ce_r1(sram_ce_r1), .sram_addr_r1(sram_addr_r1), .sram_rd_r1(sram_rd_r1)
  );

  always #5 clk = ~clk;

  // Behavioural model of the 1rw1r macro: read data appears the cycle after ce_r1.
  logic [BITS-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (sram_ce_rw1 && sram_we_rw1) mem[sram_addr_rw1] <= sram_wd_rw1;
    if (sram_ce_r1) sram_rd_r1 <= mem[sram_addr_r1];
  end

  // Reference model: the FIFO contents plus counts of port-level events.
  logic [31:0] q[$];
  int wr_cnt, rd_cnt, pop_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_cnt = 0; rd_cnt = 0; pop_cnt = 0;
  endtask

  // One clock cycle: drive, check handshake-cycle outputs, advance, check level.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
    logic acc, pop, iss;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    iss = sram_ce_r1;
    if (q.size() < DEPTH)          chk("in_ready_open", in_ready, 1);
    else if (q.size() >= DEPTH + 2) chk("in_ready_full", in_ready, 0);
    if (acc) begin
      chk("wr_ce_we", {sram_ce_rw1, sram_we_rw1}, 2'b11);
      chk("wr_addr", sram_addr_rw1, wr_cnt % DEPTH);
      chk("wr_data", sram_wd_rw1, d);
    end else begin
      chk("wr_idle", sram_ce_rw1, 0);
    end
    if (iss) begin
      chk("rd_nonempty", wr_cnt > rd_cnt, 1);
      chk("rd_addr", sram_addr_r1, rd_cnt % DEPTH);
    end
    if (q.size() == 0) chk("empty_valid", out_valid, 0);
    else if (pop)      chk("pop_data", out_data, q[0]);
    @(posedge clk); #1;
    if (acc) begin q.push_back(d); wr_cnt++; end
    if (pop) begin
      if (q.size() > 0) void'(q.pop_front());
      pop_cnt++;
    end
    if (iss) rd_cnt++;
    chk("skid_bound", (rd_cnt - pop_cnt) <= 2, 1);
    chk("level", level, q.size());
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      cycle(1'b0, 32'h0, 1'b1);
      guard++;
    end
    chk("drain_done", q.size() == 0, 1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("drain_level", level, 0);
  endtask

  initial begin
    int guard, target;
    logic seen;
    model_clear();

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ce_rw1", sram_ce_rw1, 0);
    chk("rst_we_rw1", sram_we_rw1, 0);
    chk("rst_ce_r1", sram_ce_r1, 0);
    chk("wmask", sram_wmask_rw1, 32'hFFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word latency
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("sw_valid_e0", out_valid, 0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("sw_valid_e1", out_valid, 0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("sw_valid_e2", out_valid, 1);
    chk("sw_data", out_data, 32'hDEAD_BEEF);
    cycle(1'b0, 32'h0, 1'b1);
    chk("sw_level_after_pop", level, 0);

    // Fill: 390 attempts, only DEPTH+2 fit
    for (int i = 0; i < 390; i++) cycle(1'b1, i, 1'b0);
    chk("fill_accepted", wr_cnt, 1 + DEPTH + 2);
    chk("fill_level", level, DEPTH + 2);
    chk("fill_in_ready", in_ready, 0);
    // A pop at full must not open in_ready in the same cycle
    cycle(1'b1, 32'h0BAD_0BAD, 1'b1);
    drain();

    // Streaming: continuous in and out, no gaps once primed
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 32'h0001_0000 + i, 1'b1);
      if (seen) chk("stream_gap", out_valid, 1);
      if (out_valid) seen = 1'b1;
    end
    chk("stream_accepted", q.size() <= 3, 1);
    drain();

    // Random backpressure over 5000 words
    target = wr_cnt + 5000;
    guard = 0;
    while (wr_cnt < target && guard < 40000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("bp_all_written", wr_cnt, target);
    drain();
    chk("bp_all_popped", pop_cnt, wr_cnt);

    // Asynchronous reset mid-stream at level 200
    for (int i = 0; i < 200; i++) cycle(1'b1, 32'h0002_0000 + i, 1'b0);
    chk("pre_rst_level", level, 200);
    @(posedge clk); #3;
    in_valid = 1'b1; in_data = 32'h5555_AAAA;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_level", level, 0);
    chk("mrst_ce_rw1", sram_ce_rw1, 0);
    chk("mrst_we_rw1", sram_we_rw1, 0);
    chk("mrst_ce_r1", sram_ce_r1, 0);
    in_valid = 1'b0;
    @(posedge clk); #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    cycle(1'b1, 32'hA5A5_0002, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("post_rst_first", out_data, 32'hA5A5_0001);
    drain();

`ifdef LITEETH_SRAM_FIFO_FLUSH_EN
    for (int i = 0; i < 50; i++) cycle(1'b1, 32'h0003_0000 + i, 1'b0);
    chk("pre_flush_level", level, 50);
    in_valid = 1'b1; in_data = 32'h0000_0BAD; out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_ce_rw1", sram_ce_rw1, 0);
    chk("flush_ce_r1", sram_ce_r1, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_out_valid", out_valid, 0);
    model_clear();
    cycle(1'b1, 32'h1234_5678, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("flush_next_word", out_data, 32'h1234_5678);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
